stage_mem_sequencer: RTL and testbench

Parametrised sequencer and single-port memory arbiter for a chain of processing stages. It starts `NUM_STAGES` stages one after another. Each stage owns the shared on-chip SRAM while it runs. A host port owns the SRAM only while the sequencer is idle. It generalises the two-stage build-tree / code-transform controller to N stages, with an optional per-stage watchdog.

---
 rtl/btct_pkg.sv | 23 ++
 rtl/mem_port_mux.sv | 63 ++++++
 rtl/stage_mem_sequencer.sv | 161 ++++++++++++++++
 tb/tb_stage_mem_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btct_pkg.sv
// Shared types and default widths for the stage sequencer and its memory port mux.
package btct_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_STAGES     = 2;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_HOST_ADDR_W    = 10;
  localparam int DEF_STAGE_ADDR_W   = 10;
  localparam int DEF_MEM_ADDR_W     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // A single stage still needs a one-bit index register.
  function automatic int cur_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Combinational SRAM port mux: picks host or the current stage, applies
// write-over-read priority, zero-extends addresses and routes read data back.
module mem_port_mux
  import btct_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int HOST_ADDR_W  = DEF_HOST_ADDR_W,
  parameter int STAGE_ADDR_W = DEF_STAGE_ADDR_W,
  parameter int MEM_ADDR_W   = DEF_MEM_ADDR_W,
  parameter int CUR_W        = cur_width(DEF_NUM_STAGES)
) (
  input  logic                               i_host_sel,
  input  logic [CUR_W-1:0]                   i_cur,
  input  logic                               i_host_r,
  input  logic                               i_host_w,
  input  logic [HOST_ADDR_W-1:0]             i_host_addr,
  input  logic [DATA_W-1:0]                  i_host_wdata,
  input  logic [NUM_STAGES-1:0]              i_stage_r,
  input  logic [NUM_STAGES-1:0]              i_stage_w,
  input  logic [NUM_STAGES*STAGE_ADDR_W-1:0] i_stage_addr,
  input  logic [NUM_STAGES*DATA_W-1:0]       i_stage_wdata,
  input  logic [DATA_W-1:0]                  i_mem_rdata,
  output logic                               o_mem_r,
  output logic                               o_mem_w,
  output logic [MEM_ADDR_W-1:0]              o_mem_addr,
  output logic [DATA_W-1:0]                  o_mem_wdata,
  output logic [DATA_W-1:0]                  o_host_rdata,
  output logic [DATA_W-1:0]                  o_stage_rdata
);

  logic                  w_req_r;
  logic                  w_req_w;
  logic [MEM_ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]     w_wdata;

  always_comb begin
    w_req_r = 1'b0;
    w_req_w = 1'b0;
    w_addr  = {MEM_ADDR_W{1'b0}};
    w_wdata = {DATA_W{1'b0}};
    if (i_host_sel) begin
      w_req_r = i_host_r;
      w_req_w = i_host_w;
      w_addr  = MEM_ADDR_W'(i_host_addr);
      w_wdata = i_host_wdata;
    end else begin
      w_req_r = i_stage_r[i_cur];
      w_req_w = i_stage_w[i_cur];
      w_addr  = MEM_ADDR_W'(i_stage_addr[i_cur*STAGE_ADDR_W +: STAGE_ADDR_W]);
      w_wdata = i_stage_wdata[i_cur*DATA_W +: DATA_W];
    end
  end

  // Idle port drives all zeros so the SRAM sees a clean bus between accesses.
  assign o_mem_w       = w_req_w;
  assign o_mem_r       = w_req_r & ~w_req_w;
  assign o_mem_addr    = (w_req_r | w_req_w) ? w_addr : {MEM_ADDR_W{1'b0}};
  assign o_mem_wdata   = w_req_w ? w_wdata : {DATA_W{1'b0}};
  assign o_host_rdata  = (i_host_sel & i_host_r) ? i_mem_rdata : {DATA_W{1'b0}};
  assign o_stage_rdata = (~i_host_sel & i_stage_r[i_cur]) ? i_mem_rdata : {DATA_W{1'b0}};

endmodule

// File: rtl/stage_mem_sequencer.sv
// Starts NUM_STAGES stages in turn and lends each the shared SRAM; the host owns it when idle.
// Optional per-stage watchdog enabled by defining STAGE_TIMEOUT_EN.
module stage_mem_sequencer
  import btct_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int HOST_ADDR_W    = DEF_HOST_ADDR_W,
  parameter int STAGE_ADDR_W   = DEF_STAGE_ADDR_W,
  parameter int MEM_ADDR_W     = DEF_MEM_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               all_start,
  output logic                               all_busy,
  output logic                               all_finish,
  output logic                               seq_error,
  input  logic                               host_r,
  input  logic                               host_w,
  input  logic [HOST_ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]                  host_wdata,
  output logic [DATA_W-1:0]                  host_rdata,
  output logic                               host_reject,
  output logic [NUM_STAGES-1:0]              stage_start,
  input  logic [NUM_STAGES-1:0]              stage_finish,
  input  logic [NUM_STAGES-1:0]              stage_r,
  input  logic [NUM_STAGES-1:0]              stage_w,
  input  logic [NUM_STAGES*STAGE_ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES*DATA_W-1:0]       stage_wdata,
  output logic [DATA_W-1:0]                  stage_rdata,
  output logic                               mem_r,
  output logic                               mem_w,
  output logic [MEM_ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata
);

  localparam int               CUR_W = cur_width(NUM_STAGES);
  localparam logic [CUR_W-1:0] LAST  = CUR_W'(NUM_STAGES - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CUR_W-1:0] r_cur;
  logic [CUR_W-1:0] w_cur_nxt;
  logic             r_seq_error;
  logic             w_seq_error_nxt;
  logic             r_host_reject;
  logic             w_busy;
  logic             w_fin_cur;
  logic             w_timeout;

  assign w_busy    = (r_state != IDLE);
  assign w_fin_cur = stage_finish[r_cur];

`ifdef STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // The count holds the number of RUN cycles already spent by the current stage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == START) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign w_timeout = (r_state == RUN) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_seq_error_nxt = r_seq_error;
    case (r_state)
      IDLE: begin
        if (all_start) begin
          w_state_nxt     = START;
          w_cur_nxt       = {CUR_W{1'b0}};
          w_seq_error_nxt = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: w_state_nxt = RUN;
      RUN: begin
        // A finish on the last watchdog cycle still counts as a clean finish.
        if (w_fin_cur) begin
          if (r_cur == LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_cur_nxt   = r_cur + 1'b1;
            w_state_nxt = START;
          end
        end else if (w_timeout) begin
          w_state_nxt     = DONE;
          w_seq_error_nxt = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= IDLE;
      r_cur         <= {CUR_W{1'b0}};
      r_seq_error   <= 1'b0;
      r_host_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur         <= w_cur_nxt;
      r_seq_error   <= w_seq_error_nxt;
      r_host_reject <= w_busy & (host_r | host_w);
    end
  end

  assign all_busy    = w_busy;
  assign all_finish  = (r_state == DONE);
  assign seq_error   = r_seq_error;
  assign host_reject = r_host_reject;
  assign stage_start = (r_state == START) ? (NUM_STAGES'(1) << r_cur) : {NUM_STAGES{1'b0}};

  mem_port_mux #(
    .NUM_STAGES  (NUM_STAGES),
    .DATA_W      (DATA_W),
    .HOST_ADDR_W (HOST_ADDR_W),
    .STAGE_ADDR_W(STAGE_ADDR_W),
    .MEM_ADDR_W  (MEM_ADDR_W),
    .CUR_W       (CUR_W)
  ) u_mux (
    .i_host_sel   (~w_busy),
    .i_cur        (r_cur),
    .i_host_r     (host_r),
    .i_host_w     (host_w),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .i_stage_r    (stage_r),
    .i_stage_w    (stage_w),
    .i_stage_addr (stage_addr),
    .i_stage_wdata(stage_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_mem_r      (mem_r),
    .o_mem_w      (mem_w),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_host_rdata (host_rdata),
    .o_stage_rdata(stage_rdata)
  );

endmodule

// File: tb/tb_stage_mem_sequencer.sv
// Bench for stage_mem_sequencer: directed scenarios plus random traffic, all checked
// each cycle against a stage/age model and a model copy of the SRAM.
module tb_stage_mem_sequencer;

  localparam int NS  = 3;
  localparam int DW  = 8;
  localparam int HAW = 10;
  localparam int SAW = 10;
  localparam int MAW = 16;
  localparam int TO  = 16;
`ifdef STAGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              all_start = 1'b0;
  logic              all_busy, all_finish, seq_error;
  logic              host_r = 1'b0, host_w = 1'b0;
  logic [HAW-1:0]    host_addr = '0;
  logic [DW-1:0]     host_wdata = '0;
  logic [DW-1:0]     host_rdata;
  logic              host_reject;
  logic [NS-1:0]     stage_start;
  logic [NS-1:0]     stage_finish = '0;
  logic [NS-1:0]     stage_r = '0, stage_w = '0;
  logic [NS*SAW-1:0] stage_addr = '0;
  logic [NS*DW-1:0]  stage_wdata = '0;
  logic [DW-1:0]     stage_rdata;
  logic              mem_r, mem_w;
  logic [MAW-1:0]    mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stage_mem_sequencer #(
    .NUM_STAGES(NS), .DATA_W(DW), .HOST_ADDR_W(HAW), .STAGE_ADDR_W(SAW),
    .MEM_ADDR_W(MAW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .all_start(all_start), .all_busy(all_busy),
    .all_finish(all_finish), .seq_error(seq_error), .host_r(host_r), .host_w(host_w),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_reject(host_reject), .stage_start(stage_start), .stage_finish(stage_finish),
    .stage_r(stage_r), .stage_w(stage_w), .stage_addr(stage_addr),
    .stage_wdata(stage_wdata), .stage_rdata(stage_rdata), .mem_r(mem_r), .mem_w(mem_w),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment SRAM with combinational read.
  logic [DW-1:0] sram [0:(1<<MAW)-1];
  assign mem_rdata = sram[mem_addr];
  always @(posedge clk) if (mem_w) sram[mem_addr] <= mem_wdata;

  // Behavioural model: who owns the memory, how long the current stage has run.
  logic [DW-1:0] m_mem [0:(1<<MAW)-1];
  bit m_busy = 0, m_done = 0, m_err = 0, m_rej = 0;
  int m_cur = 0, m_age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_rej = 0; m_cur = 0; m_age = 0;
    end else begin
      if (!m_busy) begin
        if (host_w) m_mem[host_addr] = host_wdata;
      end else if (stage_w[m_cur]) begin
        m_mem[stage_addr[m_cur*SAW +: SAW]] = stage_wdata[m_cur*DW +: DW];
      end
      m_rej = m_busy && (host_r || host_w);
      if (!m_busy) begin
        if (all_start) begin m_busy = 1; m_cur = 0; m_age = 0; m_err = 0; end
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (m_age > 0 && stage_finish[m_cur]) begin
        if (m_cur == NS - 1) m_done = 1;
        else begin m_cur++; m_age = 0; end
      end else if (TO_EN && m_age == TO) begin
        m_done = 1; m_err = 1;
      end else begin
        m_age++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic          sr, sw;
    logic [MAW-1:0] a;
    logic [DW-1:0]  d;
    logic [NS-1:0]  es;
    if (!m_busy) begin
      sr = host_r; sw = host_w; a = MAW'(host_addr); d = host_wdata;
    end else begin
      sr = stage_r[m_cur]; sw = stage_w[m_cur];
      a = MAW'(stage_addr[m_cur*SAW +: SAW]); d = stage_wdata[m_cur*DW +: DW];
    end
    es = (m_busy && !m_done && m_age == 0) ? NS'(1 << m_cur) : '0;
    chk("all_busy", all_busy, m_busy);
    chk("all_finish", all_finish, m_done);
    chk("seq_error", seq_error, m_err);
    chk("host_reject", host_reject, m_rej);
    chk("stage_start", stage_start, es);
    chk("mem_w", mem_w, sw);
    chk("mem_r", mem_r, sr && !sw);
    chk("mem_addr", mem_addr, (sr || sw) ? a : '0);
    if (sw || !sr) chk("mem_wdata", mem_wdata, sw ? d : '0);
    chk("host_rdata", host_rdata, (!m_busy && host_r) ? m_mem[MAW'(host_addr)] : '0);
    chk("stage_rdata", stage_rdata, (m_busy && stage_r[m_cur]) ? m_mem[a] : '0);
  end

  task automatic pulse_start();
    #1 all_start = 1'b1;
    @(negedge clk);
    #1 all_start = 1'b0;
  endtask

  task automatic wait_start(input int k, output int t);
    int n = 0;
    while (stage_start[k] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    t = cyc;
    checks++;
    if (n >= 100) begin errors++; $display("FAIL wait_start%0d: actual=timeout required=pulse", k); end
  endtask

  task automatic wait_finish(output int t);
    int n = 0;
    while (all_finish !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    t = cyc;
    checks++;
    if (n >= 200) begin errors++; $display("FAIL wait_finish: actual=timeout required=pulse"); end
  endtask

  task automatic finish_stage(input int k);
    #1 stage_finish[k] = 1'b1;
    @(negedge clk);
    #1 stage_finish[k] = 1'b0;
  endtask

  initial begin
    int t0, t1, tk;
    logic [NS-1:0] pat [NS];
    for (int i = 0; i < (1 << MAW); i++) begin sram[i] = '0; m_mem[i] = '0; end

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_busy", all_busy, 1'b0);
    chk("rst_stage_start", stage_start, 3'b000);
    chk("rst_mem_w", mem_w, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    #1 n_rst = 1'b1;

    // Host write then read in IDLE at the top host address.
    @(negedge clk);
    #1 host_w = 1'b1; host_addr = 10'h3FF; host_wdata = 8'hA5;
    #1 chk("host_w_addr", mem_addr, 16'h03FF);
    @(negedge clk);
    #1 host_w = 1'b0; host_r = 1'b1;
    #1 chk("host_rdata_a5", host_rdata, 8'hA5);
    @(negedge clk);
    #1 host_r = 1'b0;

    // Three stages each finishing 5 cycles after its start: 3*6+1 busy cycles.
    @(negedge clk);
    pulse_start();
    for (int k = 0; k < NS; k++) begin
      wait_start(k, tk);
      if (k == 0) t0 = tk;
      pat[k] = stage_start;
      repeat (5) @(negedge clk);
      finish_stage(k);
    end
    wait_finish(t1);
    chk("start_pat0", pat[0], 3'b001);
    chk("start_pat1", pat[1], 3'b010);
    chk("start_pat2", pat[2], 3'b100);
    chk("seq_len_d5", t1 - t0, 32'd18);

    // Finish held high throughout: minimum length 2*NS+1, START-cycle finish ignored.
    repeat (3) @(negedge clk);
    #1 stage_finish = 3'b111;
    pulse_start();
    wait_start(0, t0);
    wait_finish(t1);
    chk("seq_len_min", t1 - t0, 32'd6);
    #1 stage_finish = 3'b000;
    repeat (3) @(negedge clk);

    // Stage 0: r+w together, wrong-stage finish ignored; host write rejected in stage 1.
    pulse_start();
    wait_start(0, t0);
    #1 stage_r[0] = 1'b1; stage_w[0] = 1'b1;
    stage_addr[0 +: SAW] = 10'h010; stage_wdata[0 +: DW] = 8'h3C; stage_finish = 3'b010;
    #1 chk("rw_mem_w", mem_w, 1'b1);
    chk("rw_mem_r", mem_r, 1'b0);
    chk("rw_mem_addr", mem_addr, 16'h0010);
    chk("rw_mem_wdata", mem_wdata, 8'h3C);
    @(negedge clk);
    #1 stage_r = '0; stage_w = '0;
    repeat (8) @(negedge clk);
    chk("wrong_fin_busy", all_busy, 1'b1);
    chk("wrong_fin_start", stage_start, 3'b000);
    #1 stage_finish = 3'b000;
    finish_stage(0);
    wait_start(1, tk);
    @(negedge clk);
    #1 host_w = 1'b1; host_addr = 10'h3FF; host_wdata = 8'h11;
    stage_w[1] = 1'b1; stage_addr[SAW +: SAW] = 10'h020; stage_wdata[DW +: DW] = 8'h77;
    #1 chk("rej_mem_addr", mem_addr, 16'h0020);
    @(posedge clk);
    #1 host_w = 1'b0; stage_w = '0;
    @(negedge clk);
    chk("rej_pulse", host_reject, 1'b1);
    @(negedge clk);
    chk("rej_once", host_reject, 1'b0);
    finish_stage(1);
    wait_start(2, tk);
    @(negedge clk);
    finish_stage(2);
    wait_finish(t1);
    @(negedge clk);
    #1 host_r = 1'b1; host_addr = 10'h3FF;
    #1 chk("host_addr_kept", host_rdata, 8'hA5);
    #1 host_addr = 10'h010;
    #1 chk("stage_wr_seen", host_rdata, 8'h3C);
    @(negedge clk);
    #1 host_r = 1'b0;

`ifdef STAGE_TIMEOUT_EN
    // Stage 0 never finishes: DONE after 16 RUN cycles with the sticky error.
    pulse_start();
    wait_start(0, t0);
    wait_finish(t1);
    chk("to_len", t1 - t0, 32'd17);
    chk("to_err", seq_error, 1'b1);
    @(negedge clk);
    chk("to_err_sticky", seq_error, 1'b1);
    pulse_start();
    wait_start(0, t0);
    chk("to_err_clr", seq_error, 1'b0);
`else
    pulse_start();
    wait_start(0, t0);
`endif

    // Reset in the middle of RUN with the owning stage strobing.
    repeat (3) @(negedge clk);
    #1 stage_w[0] = 1'b1; stage_r[0] = 1'b1;
    #1 n_rst = 1'b0;
    #1 chk("mid_rst_busy", all_busy, 1'b0);
    chk("mid_rst_fin", all_finish, 1'b0);
    chk("mid_rst_mem_w", mem_w, 1'b0);
    chk("mid_rst_mem_r", mem_r, 1'b0);
    chk("mid_rst_err", seq_error, 1'b0);
    repeat (2) @(negedge clk);
    #1 stage_w = '0; stage_r = '0;
    #1 n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_fin", all_finish, 1'b0);
    end

    // Random traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      all_start    = ($urandom_range(0, 3) == 0);
      host_r       = $urandom_range(0, 1) == 1;
      host_w       = $urandom_range(0, 2) == 0;
      host_addr    = HAW'($urandom_range(0, 31));
      host_wdata   = DW'($urandom);
      stage_r      = NS'($urandom);
      stage_w      = NS'($urandom);
      for (int k = 0; k < NS; k++) begin
        stage_finish[k]          = ($urandom_range(0, 5) == 0);
        stage_addr[k*SAW +: SAW] = SAW'($urandom_range(0, 31));
        stage_wdata[k*DW +: DW]  = DW'($urandom);
      end
    end
    @(posedge clk);
    #1 all_start = 1'b0; host_r = 1'b0; host_w = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
